// File: rtl/mer_meas_ctrl.sv
// Measurement window sequencer for the MER chain: settles, aligns, accumulates
// 2^WIN_LOG2 symbols and latches accumulator results once per window.
module mer_meas_ctrl #(
   parameter int SETTLE_SYMS = 64,
   parameter int WIN_LOG2    = 18,
   parameter bit ALIGN_CYCLE = 1'b1,
   parameter int ACC_W       = 56
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             sym_clk_en,
   input  logic             lfsr_cycle,
   input  logic             start,
   input  logic             abort,
   input  logic             continuous,
   input  logic [ACC_W-1:0] err_sq_acc,
   input  logic [17:0]      err_acc,
   input  logic [17:0]      ref_lvl,
   output logic             clr_acc,
   output logic             acc_en,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] err_sq_out,
   output logic [17:0]      err_out,
   output logic [17:0]      ref_out,
   output logic [15:0]      win_count,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      ARM    = 3'd2,
      ACCUM  = 3'd3,
      LATCH  = 3'd4
   } state_t;

   // One counter serves both the settle phase and the window, so size it for the larger.
   localparam int SET_W = (SETTLE_SYMS > 0) ? $clog2(SETTLE_SYMS + 1) : 1;
   localparam int CNT_W = (WIN_LOG2 + 1 > SET_W) ? WIN_LOG2 + 1 : SET_W;
   localparam logic [CNT_W-1:0] WIN_LEN    = CNT_W'(1) << WIN_LOG2;
   localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_SYMS);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] sym_cnt;
   logic [CNT_W-1:0] sym_cnt_next;
   logic             start_q;
   logic             start_edge;
   logic             win_clr;

   assign start_edge = start & ~start_q;
   assign busy       = (state != IDLE);
   assign state_o    = state;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state      <= IDLE;
         sym_cnt    <= '0;
         start_q    <= 1'b0;
         win_count  <= '0;
         err_sq_out <= '0;
         err_out    <= '0;
         ref_out    <= '0;
      end else begin
         state   <= state_next;
         sym_cnt <= sym_cnt_next;
         start_q <= start;
         if (win_clr) begin
            win_count <= '0;
         end else if (done) begin
            win_count <= win_count + 16'd1;
         end
         if (done) begin
            err_sq_out <= err_sq_acc;
            err_out    <= err_acc;
            ref_out    <= ref_lvl;
         end
      end
   end

   // Abort (or reset) overrides everything and suppresses all strobes for that cycle.
   always_comb begin
      state_next   = state;
      sym_cnt_next = sym_cnt;
      clr_acc      = 1'b0;
      acc_en       = 1'b0;
      done         = 1'b0;
      win_clr      = 1'b0;
      if (reset || abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_edge) begin
                  sym_cnt_next = '0;
                  win_clr      = 1'b1;
                  state_next   = (SETTLE_SYMS == 0) ? ARM : SETTLE;
               end
            end
            SETTLE: begin
               if (sym_clk_en) begin
                  sym_cnt_next = sym_cnt + CNT_W'(1);
                  if (sym_cnt_next == SETTLE_LEN) begin
                     state_next = ARM;
                  end
               end
            end
            ARM: begin
               if (sym_clk_en && ((ALIGN_CYCLE == 1'b0) || lfsr_cycle)) begin
                  clr_acc      = 1'b1;
                  sym_cnt_next = '0;
                  state_next   = ACCUM;
               end
            end
            ACCUM: begin
               if (sym_clk_en) begin
                  acc_en       = 1'b1;
                  sym_cnt_next = sym_cnt + CNT_W'(1);
                  if (sym_cnt_next == WIN_LEN) begin
                     state_next = LATCH;
                  end
               end
            end
            LATCH: begin
               done       = 1'b1;
               state_next = continuous ? ARM : IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Directed bench for mer_meas_ctrl: one unaligned and one aligned instance share stimulus.
module tb_mer_meas_ctrl;

   localparam int ACC_W = 56;

   logic             sys_clk = 1'b0;
   logic             reset = 1'b0;
   logic             sym_clk_en = 1'b0;
   logic             lfsr_cycle = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             continuous = 1'b0;
   logic [ACC_W-1:0] err_sq_acc = '0;
   logic [17:0]      err_acc = '0;
   logic [17:0]      ref_lvl = '0;

   logic             clr_acc0, acc_en0, busy0, done0;
   logic [ACC_W-1:0] err_sq_out0;
   logic [17:0]      err_out0, ref_out0;
   logic [15:0]      win_count0;
   logic [2:0]       state0;

   logic             clr_acc1, acc_en1, busy1, done1;
   logic [ACC_W-1:0] err_sq_out1;
   logic [17:0]      err_out1, ref_out1;
   logic [15:0]      win_count1;
   logic [2:0]       state1;

   int checks = 0;
   int failures = 0;
   int phase = 0;
   int sym_num = 0;
   int lfsr_at_sym = 0;
   int cyc = 0;

   mer_meas_ctrl #(.SETTLE_SYMS(4), .WIN_LOG2(3), .ALIGN_CYCLE(1'b0), .ACC_W(ACC_W)) dut0 (
      .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .lfsr_cycle(lfsr_cycle),
      .start(start), .abort(abort), .continuous(continuous), .err_sq_acc(err_sq_acc),
      .err_acc(err_acc), .ref_lvl(ref_lvl), .clr_acc(clr_acc0), .acc_en(acc_en0),
      .busy(busy0), .done(done0), .err_sq_out(err_sq_out0), .err_out(err_out0),
      .ref_out(ref_out0), .win_count(win_count0), .state_o(state0)
   );

   mer_meas_ctrl #(.SETTLE_SYMS(4), .WIN_LOG2(3), .ALIGN_CYCLE(1'b1), .ACC_W(ACC_W)) dut1 (
      .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .lfsr_cycle(lfsr_cycle),
      .start(start), .abort(abort), .continuous(continuous), .err_sq_acc(err_sq_acc),
      .err_acc(err_acc), .ref_lvl(ref_lvl), .clr_acc(clr_acc1), .acc_en(acc_en1),
      .busy(busy1), .done(done1), .err_sq_out(err_sq_out1), .err_out(err_out1),
      .ref_out(ref_out1), .win_count(win_count1), .state_o(state1)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance one clock; symbols arrive every 16 cycles and lfsr_cycle marks a chosen symbol.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
      phase++;
      sym_clk_en = ((phase % 16) == 0);
      if (sym_clk_en) sym_num++;
      lfsr_cycle = sym_clk_en && (lfsr_at_sym != 0) && (sym_num == lfsr_at_sym);
      #2;
   endtask

   task automatic begin_start();
      phase = 8;
      sym_clk_en = 1'b0;
      lfsr_cycle = 1'b0;
      sym_num = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (state0 !== 3'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", state0); end
      checks++;
      if ({busy0, clr_acc0, acc_en0, done0} !== 4'b0000) begin
         failures++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {busy0, clr_acc0, acc_en0, done0});
      end
      checks++;
      if ({err_sq_out0, err_out0, ref_out0, win_count0} !== '0) begin
         failures++; $display("[TB] FAIL reset_outputs: got nonzero expected 0");
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_window();
      int clr_sym = -1;
      int clr_cnt = 0;
      int n_acc = 0;
      int acc8_cyc = -1;
      int done_cyc = -1;
      continuous = 1'b0;
      err_sq_acc = 56'h77;
      err_acc = 18'h00010;
      ref_lvl = 18'h00100;
      begin_start();
      for (int c = 0; c < 400 && done_cyc < 0; c++) begin
         tick();
         if (clr_acc0) begin clr_cnt++; clr_sym = sym_num; end
         if (acc_en0) begin n_acc++; if (n_acc == 8) acc8_cyc = cyc; end
         if (done0) done_cyc = cyc;
      end
      tick();
      checks++;
      if (clr_sym !== 5) begin failures++; $display("[TB] FAIL single_clr_sym: got %0d expected 5", clr_sym); end
      checks++;
      if (clr_cnt !== 1) begin failures++; $display("[TB] FAIL single_clr_count: got %0d expected 1", clr_cnt); end
      checks++;
      if (n_acc !== 8) begin failures++; $display("[TB] FAIL single_acc_count: got %0d expected 8", n_acc); end
      checks++;
      if (done_cyc < 0 || done_cyc !== acc8_cyc + 1) begin
         failures++; $display("[TB] FAIL single_done_timing: got cycle %0d expected %0d", done_cyc, acc8_cyc + 1);
      end
      checks++;
      if (win_count0 !== 16'd1) begin failures++; $display("[TB] FAIL single_win_count: got %0d expected 1", win_count0); end
      checks++;
      if (state0 !== 3'd0) begin failures++; $display("[TB] FAIL single_idle: got %0d expected 0", state0); end
      checks++;
      if (err_sq_out0 !== 56'h77 || err_out0 !== 18'h00010 || ref_out0 !== 18'h00100) begin
         failures++; $display("[TB] FAIL single_latch: got %0h/%0h/%0h expected 77/10/100", err_sq_out0, err_out0, ref_out0);
      end
   endtask

   task automatic test_continuous();
      int ndone = 0;
      int dcyc[3];
      bit pend = 1'b0;
      err_sq_acc = 56'h123;
      err_acc = 18'h3FFFF;
      ref_lvl = 18'h00155;
      continuous = 1'b1;
      begin_start();
      for (int c = 0; c < 1000 && !(ndone == 3 && !pend); c++) begin
         tick();
         if (pend) begin
            pend = 1'b0;
            checks++;
            if (win_count0 !== 16'(ndone)) begin
               failures++; $display("[TB] FAIL cont_win_count: got %0d expected %0d", win_count0, ndone);
            end
            if (ndone == 1) begin
               checks++;
               if (err_sq_out0 !== 56'h123 || err_out0 !== 18'h3FFFF || ref_out0 !== 18'h00155) begin
                  failures++; $display("[TB] FAIL cont_latch: got %0h/%0h/%0h expected 123/3ffff/155", err_sq_out0, err_out0, ref_out0);
               end
            end
            if (ndone == 2) continuous = 1'b0;
         end
         if (done0 && ndone < 3) begin dcyc[ndone] = cyc; ndone++; pend = 1'b1; end
      end
      checks++;
      if (ndone !== 3) begin
         failures++; $display("[TB] FAIL cont_done_count: got %0d expected 3", ndone);
      end else begin
         checks++;
         if (dcyc[1] - dcyc[0] !== 144 || dcyc[2] - dcyc[1] !== 144) begin
            failures++; $display("[TB] FAIL cont_spacing: got %0d,%0d expected 144,144", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
         end
      end
      checks++;
      if (state0 !== 3'd0) begin failures++; $display("[TB] FAIL cont_idle: got %0d expected 0", state0); end
   endtask

   task automatic test_align();
      int clr_sym = -1;
      int clr_cnt = 0;
      int got_done = 0;
      continuous = 1'b0;
      lfsr_at_sym = 24;
      begin_start();
      for (int c = 0; c < 1000 && got_done == 0; c++) begin
         tick();
         if (clr_acc1) begin clr_cnt++; if (clr_sym < 0) clr_sym = sym_num; end
         if (done1) got_done = 1;
      end
      lfsr_at_sym = 0;
      tick();
      checks++;
      if (clr_sym !== 24) begin failures++; $display("[TB] FAIL align_clr_sym: got %0d expected 24", clr_sym); end
      checks++;
      if (clr_cnt !== 1) begin failures++; $display("[TB] FAIL align_clr_count: got %0d expected 1", clr_cnt); end
      checks++;
      if (win_count1 !== 16'd1 || state1 !== 3'd0) begin
         failures++; $display("[TB] FAIL align_finish: got win=%0d state=%0d expected 1/0", win_count1, state1);
      end
   endtask

   task automatic test_abort();
      int n_acc = 0;
      int n_done = 0;
      err_sq_acc = 56'hABC;
      continuous = 1'b0;
      begin_start();
      for (int c = 0; c < 600 && n_acc < 5; c++) begin
         tick();
         if (acc_en0) n_acc++;
      end
      abort = 1'b1;
      #1;
      checks++;
      if (n_acc !== 5 || acc_en0 !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_suppress: got acc=%0d acc_en=%b expected 5/0", n_acc, acc_en0);
      end
      tick();
      abort = 1'b0;
      checks++;
      if (state0 !== 3'd0 || busy0 !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_idle: got state=%0d busy=%b expected 0/0", state0, busy0);
      end
      for (int c = 0; c < 300; c++) begin
         tick();
         if (done0) n_done++;
      end
      checks++;
      if (n_done !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d expected 0", n_done); end
      checks++;
      if (win_count0 !== 16'd0 || err_sq_out0 !== 56'h123) begin
         failures++; $display("[TB] FAIL abort_retain: got win=%0d sq=%0h expected 0/123", win_count0, err_sq_out0);
      end
   endtask

   task automatic test_start_held();
      int n_done = 0;
      err_sq_acc = 56'h456;
      continuous = 1'b0;
      phase = 8;
      sym_clk_en = 1'b0;
      sym_num = 0;
      start = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (done0) n_done++;
      end
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy0 !== 1'b1) begin failures++; $display("[TB] FAIL held_busy: got %b expected 1", busy0); end
      for (int c = 0; c < 600; c++) begin
         tick();
         if (done0) n_done++;
      end
      checks++;
      if (n_done !== 1) begin failures++; $display("[TB] FAIL held_one_run: got %0d expected 1", n_done); end
      checks++;
      if (win_count0 !== 16'd1 || state0 !== 3'd0 || err_sq_out0 !== 56'h456) begin
         failures++; $display("[TB] FAIL held_result: got win=%0d state=%0d sq=%0h expected 1/0/456", win_count0, state0, err_sq_out0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL start_abort_busy: got %b expected 0", busy0); end
      tick();
      checks++;
      if (busy0 !== 1'b0 || state0 !== 3'd0) begin
         failures++; $display("[TB] FAIL start_abort_idle: got busy=%b state=%0d expected 0/0", busy0, state0);
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      int n_acc = 0;
      err_sq_acc = 56'h999;
      continuous = 1'b1;
      begin_start();
      for (int c = 0; c < 800 && n_acc < 3; c++) begin
         tick();
         if (done0) ndone++;
         if (acc_en0 && ndone == 1) n_acc++;
      end
      checks++;
      if (state0 !== 3'd3 || win_count0 !== 16'd1 || err_sq_out0 !== 56'h999) begin
         failures++; $display("[TB] FAIL rst_pre: got state=%0d win=%0d sq=%0h expected 3/1/999", state0, win_count0, err_sq_out0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      continuous = 1'b0;
      #1;
      checks++;
      if (state0 !== 3'd0 || {busy0, clr_acc0, acc_en0, done0} !== 4'b0000) begin
         failures++; $display("[TB] FAIL rst_mid_state: got state=%0d strobes=%b expected 0/0000", state0, {busy0, clr_acc0, acc_en0, done0});
      end
      checks++;
      if ({err_sq_out0, err_out0, ref_out0, win_count0} !== '0) begin
         failures++; $display("[TB] FAIL rst_mid_outputs: got sq=%0h win=%0d expected 0/0", err_sq_out0, win_count0);
      end
      repeat (40) tick();
      checks++;
      if (state0 !== 3'd0 || state1 !== 3'd0) begin
         failures++; $display("[TB] FAIL rst_stays_idle: got %0d/%0d expected 0/0", state0, state1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_window();
      test_continuous();
      test_align();
      test_abort();
      test_start_held();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mer_meas_ctrl.md
Name: mer_meas_ctrl

Overview:
- Sequences symbol-rate error/power measurement windows for the receive-side MER chain: slicer error, avg_err, avg_err_squared, avg_mag.
- Generates the accumulator clear and enable strobes, counts symbols per window, and optionally aligns windows to the LFSR cycle marker.
- Latches accumulator results into stable output registers once per window.
- Sits between the clk_en symbol enable and the accumulator blocks; driven from switch/key-level start and abort controls.

Parameters:
- SETTLE_SYMS, 64, symbol enables to wait after start before the first window (filter pipeline flush); 0 permitted.
- WIN_LOG2, 18, window length = 2^WIN_LOG2 symbols.
- ALIGN_CYCLE, 1, 1 = first window starts on the first sym_clk_en at or after lfsr_cycle; 0 = starts immediately after settle.
- ACC_W, 56, width of squared-error accumulator input.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- sym_clk_en  in  1  one-sys_clk symbol enable from clk_en
- lfsr_cycle  in  1  LFSR period marker, level or pulse, sampled only on sym_clk_en
- start  in  1  rising-edge-detected request to begin measurement
- abort  in  1  level; forces return to IDLE
- continuous  in  1  1 = back-to-back windows; 0 = single window
- err_sq_acc  in  ACC_W  signed squared-error accumulator value
- err_acc  in  18  signed error accumulator value
- ref_lvl  in  18  signed reference level
- clr_acc  out  1  accumulator clear strobe
- acc_en  out  1  accumulator enable (gated symbol enable)
- busy  out  1  high in any state except IDLE
- done  out  1  one-sys_clk pulse per completed window
- err_sq_out  out  ACC_W  latched err_sq_acc
- err_out  out  18  latched err_acc
- ref_out  out  18  latched ref_lvl
- win_count  out  16  completed windows since start, wraps 0xFFFF→0
- state_o  out  3  current state encoding

Behaviour:
- One clock domain (sys_clk). Reset is synchronous, active-high. All registers update only on posedge sys_clk.
- Reset values: all outputs 0; state IDLE; counters 0.
- start is edge-detected with a registered copy. A start held high does not retrigger.
- State encoding: IDLE=0, SETTLE=1, ARM=2, ACCUM=3, LATCH=4.
- IDLE:
  - On start edge: zero the symbol counter, zero win_count.
  - Go to SETTLE, or directly to ARM when SETTLE_SYMS=0.
- SETTLE:
  - Symbol counter increments on each sym_clk_en.
  - On the sym_clk_en that makes the count equal SETTLE_SYMS, go to ARM.
- ARM:
  - ALIGN_CYCLE=0: on the next sym_clk_en, assert clr_acc for that single sys_clk, zero the counter, go to ACCUM.
  - ALIGN_CYCLE=1: same action, but only on a sym_clk_en where lfsr_cycle=1.
- ACCUM:
  - acc_en = sym_clk_en, combinational AND of state==ACCUM and sym_clk_en.
  - The clearing symbol counts as symbol 0 and is not an acc_en symbol; the accumulators clear on it.
  - The counter increments per sym_clk_en. On the sym_clk_en that reaches 2^WIN_LOG2, go to LATCH. Counter width is WIN_LOG2+1.
- LATCH (exactly one sys_clk):
  - Register err_sq_acc, err_acc and ref_lvl into the outputs.
  - Pulse done. Increment win_count.
  - continuous=1: go to ARM (alignment re-applies).
  - continuous=0: go to IDLE.
- clr_acc is only ever asserted coincident with sym_clk_en.
- Latched outputs hold their values until the next LATCH or reset. abort does not clear them.
- abort high in any state: next state IDLE; clr_acc, acc_en and done are suppressed that cycle. A partial window is never latched and win_count is unchanged.
- abort and a start edge in the same cycle: abort wins and the start edge is discarded.
- A start edge while busy is ignored.
- A sym_clk_en coincident with the LATCH cycle is not lost: the ARM logic evaluates only the cycle after LATCH. The clk_en contract guarantees sym_clk_en spacing ≥ 4 sys_clk.
- Reset mid-window behaves as abort plus clearing the outputs.

Test Plan:
- ALIGN_CYCLE=0, SETTLE_SYMS=4, WIN_LOG2=3, sym_clk_en every 16 sys_clk, single start pulse:
  - clr_acc appears on the 5th sym_clk_en after start.
  - Exactly 8 acc_en pulses follow.
  - done appears 1 sys_clk after the 8th.
  - win_count=1, state returns to IDLE.
- continuous=1, constant err_sq_acc=56'h123, err_acc=18'h3FFFF:
  - 3 done pulses exactly 9 symbols apart.
  - err_sq_out=56'h123 and err_out=-1 after the first done.
  - win_count steps 1, 2, 3.
- ALIGN_CYCLE=1, lfsr_cycle asserted on the 20th symbol after settle:
  - No clr_acc before that symbol; clr_acc is coincident with it.
- abort on the 5th acc_en:
  - state goes to IDLE next cycle.
  - No done pulse, win_count unchanged, previous err_sq_out retained.
- start held high 100 cycles and then re-pulsed while busy:
  - Exactly one measurement runs.
  - Same-cycle start and abort from IDLE leaves busy=0.
- Sync reset asserted in ACCUM:
  - Next cycle all outputs read 0 and state_o=0.
  - A reset of one cycle's duration is sufficient.
